// File: rtl/mgmt_irq_controller.sv
// rtl/mgmt_irq_controller.sv - event-to-irq aggregator with W1C status; IRQ_CTRL_GLITCH_FILTER_EN adds a 3-sample input filter
module mgmt_irq_controller #(
  parameter int         NUM_SRC        = 8,
  parameter logic [7:0] INVERT         = 8'h00,
  parameter int         HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  input  logic [1:0]         rd_addr,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic               irq
);

  // Bits at or above NUM_SRC are tied off so they read 0 and ignore writes.
  localparam logic [8:0] SRC_MASK9 = (9'd1 << NUM_SRC) - 9'd1;
  localparam logic [7:0] SRC_MASK  = SRC_MASK9[7:0];
  localparam logic [7:0] INV       = INVERT & SRC_MASK;
  localparam int         CW        = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  logic [7:0]    src_w;
  logic [7:0]    sync1, sync2;
  logic [7:0]    clean;
  logic [7:0]    lvl, prev, rise;
  logic [7:0]    status, mask, pending, clr;
  state_t        state;
  logic [CW-1:0] cnt;

  assign src_w = 8'(src);

  // Two-flop synchronizer on the asynchronous event inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= src_w & SRC_MASK;
      sync2 <= sync1;
    end
  end

`ifdef IRQ_CTRL_GLITCH_FILTER_EN
  logic [7:0] hist1, hist2, filt, stable;

  // A bit follows the synchronizer only once the current sample and the two before it agree.
  assign stable = ~(sync2 ^ hist1) & ~(hist1 ^ hist2);
  assign clean  = (stable & sync2) | (~stable & filt);

  // Sample history and the held filter output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1 <= 8'h00;
      hist2 <= 8'h00;
      filt  <= 8'h00;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      filt  <= clean;
    end
  end
`else
  assign clean = sync2;
`endif

  assign lvl     = (clean ^ INV) & SRC_MASK;
  assign rise    = lvl & ~prev;
  assign pending = status & mask;
  assign clr     = (wr_en && wr_addr == 2'd0) ? wr_data : 8'h00;

  // Edge detection and register file; a new edge beats a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= 8'h00;
      status <= 8'h00;
      mask   <= 8'h00;
    end else begin
      prev   <= lvl;
      status <= ((status & ~clr) | rise) & SRC_MASK;
      if (wr_en && wr_addr == 2'd1)
        mask <= wr_data & SRC_MASK;
    end
  end

  // Registered read port; returns the state seen before any same-cycle write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        case (rd_addr)
          2'd0:    rd_data <= status;
          2'd1:    rd_data <= mask;
          2'd2:    rd_data <= lvl;
          default: rd_data <= pending;
        endcase
      end else begin
        rd_data <= 8'h00;
      end
    end
  end

  // IRQ FSM: holdoff forces a minimum low time so the MCU always sees a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      irq   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            state <= ACTIVE;
            irq   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (pending == 8'h00) begin
            irq <= 1'b0;
            cnt <= HOLD_LOAD;
            if (HOLDOFF_CYCLES == 0)
              state <= IDLE;
            else
              state <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_irq_controller.sv
// tb/tb_mgmt_irq_controller.sv - directed-vector bench for mgmt_irq_controller
module tb_mgmt_irq_controller;

`ifdef IRQ_CTRL_GLITCH_FILTER_EN
  localparam int LAT        = 5;
  localparam int GLITCH_EXP = 'h00;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_EXP = 'h10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = 8'h00;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [1:0] rd_addr = 2'd0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  mgmt_irq_controller #(
    .NUM_SRC(8),
    .INVERT(8'h02),
    .HOLDOFF_CYCLES(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .src(src),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input int exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk(tag, 32'({rd_valid, rd_data}), 32'h100 | exp);
  endtask

  // Raise src[idx] for 4 cycles; irq must rise exactly LAT edges after capture.
  task automatic fire(input int idx, input string tag);
    src[idx] = 1'b1;
    for (int j = 1; j <= LAT + 1; j++) begin
      step();
      chk(tag, 32'(irq), (j == LAT + 1) ? 1 : 0);
      if (j == 4) src[idx] = 1'b0;
    end
  endtask

  initial begin
    repeat (3) step();
    chk("reset_outputs", 32'({irq, rd_valid, rd_data}), 0);
    rst = 1'b0;
    repeat (3) step();

    // Active-low src[1] held low through reset release
    rd("inv_raw", 2'd2, 'h02);
    rd("inv_status", 2'd0, 'h02);
    wr(2'd0, 8'h02);
    rd("inv_cleared", 2'd0, 'h00);

    // Basic edge -> status -> irq, then W1C clear
    wr(2'd1, 8'h01);
    rd("mask_rd", 2'd1, 'h01);
    fire(0, "irq_rise_s0");
    rd("status_s0", 2'd0, 'h01);
    wr(2'd0, 8'h01);
    chk("irq_still_hi", 32'(irq), 1);
    step();
    chk("irq_fall", 32'(irq), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("irq_stay_low", 32'(irq), 0);
    end

    // Event arriving during holdoff
    wr(2'd1, 8'h05);
    fire(0, "irq_rise_s0b");
    wr(2'd0, 8'h01);
    chk("irq_hi_pre", 32'(irq), 1);
    step();
    chk("irq_fall_b", 32'(irq), 0);
    src[2] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("holdoff_low", 32'(irq), 0);
      if (i == 4) src[2] = 1'b0;
    end
    step();
    chk("holdoff_rise", 32'(irq), 1);
    rd("status_s2", 2'd0, 'h04);
    rd("pending_s2", 2'd3, 'h04);
    wr(2'd0, 8'h04);
    repeat (20) step();

    // Same-cycle set and clear of status bit 3
    wr(2'd1, 8'h08);
    src[3] = 1'b1;
    for (int j = 1; j <= LAT - 1; j++) step();
    wr(2'd0, 8'h08);
    rd("set_wins_status", 2'd0, 'h08);
    rd("set_wins_pending", 2'd3, 'h08);
    src[3] = 1'b0;
    chk("set_wins_irq", 32'(irq), 1);
    wr(2'd0, 8'h08);
    repeat (20) step();

    // Writes to RO registers are ignored
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'hFF);
    rd("ro_mask", 2'd1, 'h08);
    rd("ro_status", 2'd0, 'h00);

    // Short pulse vs long pulse
    wr(2'd1, 8'h00);
    src[4] = 1'b1;
    repeat (2) step();
    src[4] = 1'b0;
    repeat (8) step();
    rd("short_pulse", 2'd0, GLITCH_EXP);
    wr(2'd0, 8'h10);
    repeat (3) step();
    src[4] = 1'b1;
    repeat (5) step();
    src[4] = 1'b0;
    repeat (8) step();
    rd("long_pulse", 2'd0, 'h10);

    // Back-to-back reads, first one concurrent with a clear
    wr(2'd1, 8'h10);
    rd_en = 1'b1; rd_addr = 2'd0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h10;
    step();
    wr_en = 1'b0;
    chk("b2b_status", 32'({rd_valid, rd_data}), 'h110);
    rd_addr = 2'd1;
    step();
    chk("b2b_mask", 32'({rd_valid, rd_data}), 'h110);
    rd_addr = 2'd2;
    step();
    chk("b2b_raw", 32'({rd_valid, rd_data}), 'h102);
    rd_addr = 2'd3;
    step();
    chk("b2b_pending", 32'({rd_valid, rd_data}), 'h100);
    rd_en = 1'b0;
    step();
    chk("b2b_done", 32'(rd_valid), 0);
    repeat (20) step();

    // Reset asserted mid-read with irq high
    src[4] = 1'b1;
    repeat (4) step();
    src[4] = 1'b0;
    repeat (4) step();
    chk("pre_rst_irq", 32'(irq), 1);
    rd_en = 1'b1; rd_addr = 2'd0;
    step();
    chk("pre_rst_rd", 32'({rd_valid, rd_data}), 'h110);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'({irq, rd_valid, rd_data}), 0);
    step();
    chk("rst_no_valid", 32'(rd_valid), 0);
    rd_en = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    rd("post_rst_status", 2'd0, 'h02);
    rd("post_rst_mask", 2'd1, 'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
